// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// parity-mode constants and counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a
// registered overrun pulse for pushes that could not be stored.
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign pop   = pop_req && valid;
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !wr_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: synchronizer, start/data/parity/stop FSM and
// an FWFT FIFO that carries each word with its parity and framing flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Sample_clk,
  input  logic                          rst,
  input  logic                          Serial_in,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [WORD_SIZE-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int SW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(WORD_SIZE);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  logic                 sync_p0;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state, state_nxt;
  logic [SW-1:0]        samp_cnt, samp_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [WORD_SIZE-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 ferr_acc, ferr_nxt;
  logic                 push;
  logic                 par_err;
  logic                 tick_last;
  logic                 head_vld;
  logic [WORD_SIZE+1:0] head;

  function automatic logic parity_mismatch(input logic [WORD_SIZE-1:0] d, input logic p);
    return (PARITY_EN != 0) && ((^d ^ p) != PAR_MODE);
  endfunction

  // Stage p0/p1: two-flop synchronizer, idle-high; rx_prev feeds edge detect
  always_ff @(posedge Sample_clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_p0 <= Serial_in;
      rx_s    <= sync_p0;
      rx_prev <= rx_s;
    end
  end

  // Receiver FSM
  always_ff @(posedge Sample_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      state    <= state_nxt;
      samp_cnt <= samp_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      ferr_acc <= ferr_nxt;
    end
  end

  assign tick_last = (samp_cnt == SAMP_LAST);

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;
    ferr_nxt  = ferr_acc;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = ST_START;
          samp_nxt  = '0;
          bit_nxt   = '0;
          par_nxt   = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end else if (samp_cnt == HALF_LAST) begin
          state_nxt = ST_DATA;
          samp_nxt  = '0;
        end else begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          samp_nxt  = '0;
          shift_nxt = {rx_s, shift[WORD_SIZE-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick_last) begin
          samp_nxt  = '0;
          par_nxt   = rx_s;
          state_nxt = ST_STOP;
        end else begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick_last) begin
          samp_nxt = '0;
          ferr_nxt = ferr_acc | ~rx_s;
          if (bit_cnt == STOP_LAST) begin
            push      = 1'b1;
            bit_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign par_err = parity_mismatch(shift, par_bit);

  // Output FIFO: word travels with {frame_err, parity_err}
  rx_fifo #(
    .WIDTH (WORD_SIZE + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Sample_clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ferr_acc | ~rx_s, par_err, shift}),
    .pop_req   (rd_ready),
    .valid     (head_vld),
    .head      (head),
    .overrun   (overrun),
    .count     (fifo_count)
  );

  assign rd_valid      = head_vld;
  assign rd_data       = head_vld ? head[WORD_SIZE-1:0] : '0;
  assign rd_parity_err = head_vld & head[WORD_SIZE];
  assign rd_frame_err  = head_vld & head[WORD_SIZE+1];
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default instance and a parity-enabled
// instance, with expected words queued at send time and popped on read.
module tb_uart_rx_param;

  localparam int OS = 8;

  logic       Sample_clk = 1'b0;
  logic       rst, ser_a, ser_b, rdy_a, rdy_b;
  logic       vld_a, vld_b, pe_a, pe_b, fe_a, fe_b, ovr_a, ovr_b, busy_a, busy_b;
  logic [7:0] dat_a, dat_b;
  logic [2:0] cnt_a, cnt_b;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int         checks = 0;
  int         failures = 0;
  int         ovr_seen = 0;
  int         busy_seen = 0;

  always #5 Sample_clk = ~Sample_clk;

  uart_rx_param u_a (
    .Sample_clk(Sample_clk), .rst(rst), .Serial_in(ser_a), .rd_ready(rdy_a),
    .rd_valid(vld_a), .rd_data(dat_a), .rd_parity_err(pe_a), .rd_frame_err(fe_a),
    .overrun(ovr_a), .fifo_count(cnt_a), .busy(busy_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .Sample_clk(Sample_clk), .rst(rst), .Serial_in(ser_b), .rd_ready(rdy_b),
    .rd_valid(vld_b), .rd_data(dat_b), .rd_parity_err(pe_b), .rd_frame_err(fe_b),
    .overrun(ovr_b), .fifo_count(cnt_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are settled at the falling edge; anything read now is what the
  // DUT will act on at the next rising edge.
  task automatic tick();
    logic [9:0] e;
    if (vld_a && rdy_a) begin
      e = (q_a.size() != 0) ? q_a.pop_front() : 10'bx;
      chk("word_a", 32'({fe_a, pe_a, dat_a}), 32'(e));
    end else if (!vld_a) begin
      chk("empty_zero_a", 32'({fe_a, pe_a, dat_a}), 32'(0));
    end
    if (vld_b && rdy_b) begin
      e = (q_b.size() != 0) ? q_b.pop_front() : 10'bx;
      chk("word_b", 32'({fe_b, pe_b, dat_b}), 32'(e));
    end
    if (ovr_a) ovr_seen++;
    if (busy_a) busy_seen++;
    @(negedge Sample_clk);
  endtask

  task automatic send_bit(input bit sel, input logic v);
    if (sel) ser_b = v; else ser_a = v;
    repeat (OS) tick();
  endtask

  task automatic send_head(input bit sel, input logic [7:0] d);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    send_head(sel, d);
    if (use_par) send_bit(sel, par);
    send_bit(sel, stop);
    if (sel) ser_b = 1'b1; else ser_a = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    rst = 1'b1; ser_a = 1'b1; ser_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    @(negedge Sample_clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid_a", 32'(vld_a), 32'(0));
    chk("rst_data_a",  32'({fe_a, pe_a, dat_a}), 32'(0));
    chk("rst_ovr_a",   32'(ovr_a), 32'(0));
    chk("rst_count_a", 32'(cnt_a), 32'(0));
    chk("rst_busy_a",  32'(busy_a), 32'(0));
    chk("rst_all_b",   32'({vld_b, fe_b, pe_b, dat_b, ovr_b, cnt_b, busy_b}), 32'(0));

    // Clean 0xA5: word appears exactly as busy drops
    q_a.push_back(10'h0A5);
    d = 8'hA5;
    send_head(1'b0, d);
    ser_a = 1'b1;
    n = 0;
    while (busy_a && n < 2 * OS) begin
      tick();
      n++;
    end
    chk("busy_fall", 32'(busy_a), 32'(0));
    chk("valid_at_busy_fall", 32'(vld_a), 32'(1));
    tick();
    chk("single_pulse", 32'(vld_a), 32'(0));
    repeat (4) tick();

    // Start glitch of two ticks
    busy_seen = 0;
    ser_a = 1'b0;
    repeat (2) tick();
    ser_a = 1'b1;
    repeat (5) tick();
    chk("glitch_started", 32'(busy_seen > 0), 32'(1));
    chk("glitch_busy_clear", 32'(busy_a), 32'(0));
    chk("glitch_no_push", 32'(cnt_a), 32'(0));

    // Even parity: 0x03 has even ones, so parity bit 1 is an error
    q_b.push_back(10'h103);
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    q_b.push_back(10'h007);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    q_b.push_back(10'h003);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);

    // Bad stop bit, line held low, then a clean frame
    q_a.push_back(10'h25A);
    send_head(1'b0, 8'h5A);
    send_bit(1'b0, 1'b0);
    ser_a = 1'b0;
    repeat (40) tick();
    ser_a = 1'b1;
    repeat (8) tick();
    q_a.push_back(10'h011);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("break_queue_drained", 32'(q_a.size()), 32'(0));

    // Fill the FIFO and overflow it once
    rdy_a = 1'b0;
    ovr_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_a.push_back(10'(k));
      send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
    end
    chk("full_count", 32'(cnt_a), 32'(4));
    chk("overrun_pulses", 32'(ovr_seen), 32'(1));
    chk("full_head", 32'(dat_a), 32'(1));
    rdy_a = 1'b1;
    repeat (8) tick();
    chk("drain_queue", 32'(q_a.size()), 32'(0));
    chk("drain_count", 32'(cnt_a), 32'(0));

    // Reset mid-frame with a word parked in the FIFO
    rdy_a = 1'b0;
    q_a.push_back(10'h099);
    send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("parked_valid", 32'(vld_a), 32'(1));
    d = 8'h3C;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, d[i]);
    ser_a = d[3];
    repeat (OS / 2) tick();
    chk("pre_rst_busy", 32'(busy_a), 32'(1));
    rst = 1'b1;
    tick();
    chk("midrst_outputs", 32'({vld_a, fe_a, pe_a, dat_a, ovr_a, cnt_a, busy_a}), 32'(0));
    q_a.delete();
    rst = 1'b0;
    ser_a = 1'b1;
    rdy_a = 1'b1;
    repeat (4) tick();
    chk("post_rst_idle", 32'({vld_a, busy_a}), 32'(0));
    q_a.push_back(10'h077);
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("post_rst_queue", 32'(q_a.size()), 32'(0));
    chk("parity_queue", 32'(q_b.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter WORD_SIZE, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter OVERSAMPLE, default 8, Sample_clk ticks per bit, even, legal 4..16.
REQ-003 Parameter PARITY_EN, default 0, 1 = parity bit follows data.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, power of 2, legal 2..16.
REQ-007 Sample_clk  in  1  sole clock; one tick = one sample.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 Serial_in  in  1  asynchronous serial line, idle high.
REQ-010 rd_ready  in  1  host accepts head word this cycle.
REQ-011 rd_valid  out  1  FIFO non-empty.
REQ-012 rd_data  out  WORD_SIZE  head word, LSB = first received bit.
REQ-013 rd_parity_err  out  1  parity mismatch flag of head word.
REQ-014 rd_frame_err  out  1  stop-bit error flag of head word.
REQ-015 overrun  out  1  one-cycle pulse; a completed frame was dropped.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH)+1  stored word count.
REQ-017 busy  out  1  receiver FSM not in IDLE.

Function
REQ-018 Serial_in passes through a 2-flop synchronizer; all FSM decisions use its output (rx_s) and the previous rx_s value.
REQ-019 FSM states are IDLE, START, DATA, PARITY, STOP, with a sample counter and a bit counter.
REQ-020 IDLE -> START only on a falling edge of rx_s (previous 1, current 0); a line held low never retriggers.
REQ-021 START: rx_s=1 at any tick -> IDLE (glitch reject, no push); rx_s=0 for OVERSAMPLE/2 consecutive ticks -> DATA with sample counter cleared.
REQ-022 DATA/PARITY/STOP: each bit is sampled on the tick the sample counter reaches OVERSAMPLE-1, after which the counter clears.
REQ-023 DATA shifts the sample into the MSB end of the shift register, so the first bit lands in bit 0 after WORD_SIZE samples; it then goes to PARITY if PARITY_EN, else STOP.
REQ-024 Parity error = (XOR of data bits XOR parity sample) != PARITY_ODD.
REQ-025 STOP samples STOP_BITS bits; frame error is set if any stop sample is 0.
REQ-026 On the final stop sample the word and both flags are pushed to the FIFO in that cycle, and the FSM goes to IDLE.
REQ-027 Errored words are still delivered; flags travel with their word.
REQ-028 The FIFO is first-word-fall-through: rd_valid and the head outputs update the cycle after a push into an empty FIFO.
REQ-029 A pop occurs when rd_valid && rd_ready.
REQ-030 A push while full with no pop is dropped: overrun pulses high one cycle and FIFO contents are unchanged.
REQ-031 A simultaneous push and pop while full accepts the push, with no overrun and fifo_count unchanged.
REQ-032 A simultaneous push and pop while empty leaves fifo_count = 1 next cycle.
REQ-033 rd_ready with rd_valid=0 is ignored.
REQ-034 rd_data and the flags are 0 whenever rd_valid=0.

Reset
REQ-035 rst, sampled on a Sample_clk edge, forces state IDLE, clears all counters, shift register, FIFO pointers and synchronizer flops (synchronizer reset to 1).
REQ-036 After reset, all outputs are 0.
REQ-037 rst mid-frame discards the partial frame; the next frame needs a fresh falling edge.

Structure
REQ-038 Shared package uart_pkg holds the FSM state encoding, the parity-mode constants, and a function computing counter widths.
REQ-039 The block has one sub-module, rx_fifo: a parametrised synchronous FWFT FIFO of width WORD_SIZE+2 and depth FIFO_DEPTH, with count output.

Verification (defaults unless stated)
REQ-040 Frame 0xA5, 1 stop, rd_ready=1 -> one rd_valid pulse with rd_data=0xA5 and both flags 0; busy falls on the push cycle.
REQ-041 Serial_in low for 2 ticks, then high -> busy returns 0 within 5 ticks; no push.
REQ-042 PARITY_EN=1, PARITY_ODD=0, data 0x03 with parity bit 1 -> rd_data=0x03, rd_parity_err=1.
REQ-043 Data 0x5A, stop bit 0, line held low 40 ticks then high, then frame 0x11 -> first word 0x5A with rd_frame_err=1; no spurious word; second word 0x11 clean.
REQ-044 FIFO_DEPTH=4, rd_ready=0, five frames 0x01..0x05 -> fifo_count=4; one overrun pulse on the fifth push; drain yields 0x01..0x04 in order.
REQ-045 rst asserted during data bit 3 of 0x3C -> all outputs 0 next cycle; a following frame 0x77 is received correctly.
